// File: rtl/snap_trig_capture_ctrl.sv
// snap_trig_capture_ctrl
// Write sequencer for one snap-block capture BRAM in the user clock domain.
// Software arms it through a control register and chooses a signed trigger
// offset. A negative offset runs a circular pre-trigger capture, a positive
// offset delays the capture after the trigger, and zero captures from the
// trigger onwards. When DEPTH words have been captured it reports done, busy,
// pre_short and the address of the oldest word through a status word.
module snap_trig_capture_ctrl #(
    parameter int ADDR_W   = 11,
    parameter int OFFSET_W = 32
) (
    input  logic                user_clk,
    input  logic                user_rst_n,
    input  logic [31:0]         ctrl,
    input  logic [OFFSET_W-1:0] trig_offset,
    input  logic                trig,
    input  logic                din_valid,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic                bram_we,
    output logic [31:0]         status
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [ADDR_W-1:0]   ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]   MAG_MAX  = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]    DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [OFFSET_W:0]   EXT_ONE  = (OFFSET_W + 1)'(1);
    localparam logic [OFFSET_W:0]   EXT_MAX  = (OFFSET_W + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t              state;
    logic                ctrl0_q;
    logic                lat_neg;       // latched offset sign (1 = pre-trigger capture)
    logic [ADDR_W-1:0]   lat_mag;       // latched, clamped offset magnitude
    logic [ADDR_W-1:0]   addr;          // next BRAM address to write
    logic [CNT_W-1:0]    pre_cnt;       // pre-trigger samples seen, saturates at DEPTH
    logic [CNT_W-1:0]    remaining;     // post-trigger writes still owed
    logic [ADDR_W-1:0]   skip;          // samples still to discard in DELAY
    logic                done_r;
    logic                busy_r;
    logic                pre_short_r;
    logic [ADDR_W-1:0]   start_addr_r;

    logic                vld;
    logic                trg;
    logic                arm_edge;
    logic                off_neg;
    logic [OFFSET_W:0]   off_abs;
    logic [ADDR_W-1:0]   off_mag;
    logic [CNT_W-1:0]    rem_pre;
    logic                wr_now;
    logic                ctrl_unused;

    // Software overrides OR into the live strobes; arming acts on a rising edge only.
    assign vld      = din_valid | ctrl[2];
    assign trg      = trig | ctrl[1];
    assign arm_edge = ctrl[0] & ~ctrl0_q;

    // Remaining control bits are reserved.
    assign ctrl_unused = ^ctrl[31:3];

    // Post-trigger budget in a pre-trigger capture: the rest of the buffer.
    assign rem_pre = DEPTH_C - {1'b0, lat_mag};

    // Offset magnitude, one bit wider so the most negative offset cannot overflow, then clamped.
    always_comb begin
        // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
        off_neg = trig_offset[OFFSET_W-1];
        off_abs = {1'b0, trig_offset};
        off_mag = MAG_MAX;
        if (off_neg) begin
            off_abs = (~{1'b1, trig_offset}) + EXT_ONE;
        end
        if (off_abs <= EXT_MAX) begin
            off_mag = off_abs[ADDR_W-1:0];
        end
    end

    // Decide whether the current sample is written to the BRAM.
    always_comb begin
        wr_now = 1'b0;
        if (!arm_edge && vld) begin
            case (state)
                S_ARMED:   wr_now = lat_neg || (trg && (lat_mag == '0));
                S_CAPTURE: wr_now = 1'b1;
                default:   wr_now = 1'b0;
            endcase
        end
    end

    // Capture state machine with registered BRAM strobes and status fields.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state        <= S_IDLE;
            ctrl0_q      <= 1'b0;
            lat_neg      <= 1'b0;
            lat_mag      <= '0;
            addr         <= '0;
            pre_cnt      <= '0;
            remaining    <= '0;
            skip         <= '0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
            pre_short_r  <= 1'b0;
            start_addr_r <= '0;
            bram_addr    <= '0;
            bram_we      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge state.
            ctrl0_q <= ctrl[0];
            bram_we <= wr_now;
            if (wr_now) begin
                bram_addr <= addr;
                addr      <= addr + ADDR_ONE;
            end

            if (arm_edge) begin
                // Arming wins over anything else that happens in the same cycle.
                state       <= S_ARMED;
                lat_neg     <= off_neg;
                lat_mag     <= off_mag;
                addr        <= '0;
                bram_addr   <= '0;
                pre_cnt     <= '0;
                done_r      <= 1'b0;
                busy_r      <= 1'b1;
                pre_short_r <= 1'b0;
            end else begin
                case (state)
                    S_ARMED: begin
                        if (trg) begin
                            if (lat_neg) begin
                                // Oldest kept sample is |off| writes behind the write pointer.
                                start_addr_r <= addr - lat_mag;
                                pre_short_r  <= (pre_cnt < {1'b0, lat_mag});
                                if (vld) begin
                                    remaining <= rem_pre - CNT_ONE;
                                    state     <= (rem_pre == CNT_ONE) ? S_DONE : S_CAPTURE;
                                end else begin
                                    remaining <= rem_pre;
                                    state     <= S_CAPTURE;
                                end
                            end else begin
                                start_addr_r <= addr;
                                if (lat_mag == '0) begin
                                    remaining <= vld ? (DEPTH_C - CNT_ONE) : DEPTH_C;
                                    state     <= S_CAPTURE;
                                end else begin
                                    remaining <= DEPTH_C;
                                    // A sample in the trigger cycle is the first one skipped.
                                    if (vld && (lat_mag == ADDR_ONE)) begin
                                        skip  <= '0;
                                        state <= S_CAPTURE;
                                    end else begin
                                        skip  <= vld ? (lat_mag - ADDR_ONE) : lat_mag;
                                        state <= S_DELAY;
                                    end
                                end
                            end
                        end else if (vld && lat_neg && (pre_cnt != DEPTH_C)) begin
                            pre_cnt <= pre_cnt + CNT_ONE;
                        end
                    end

                    S_DELAY: begin
                        if (vld) begin
                            skip <= skip - ADDR_ONE;
                            if (skip == ADDR_ONE) begin
                                state <= S_CAPTURE;
                            end
                        end
                    end

                    S_CAPTURE: begin
                        if (vld) begin
                            remaining <= remaining - CNT_ONE;
                            if (remaining == CNT_ONE) begin
                                state <= S_DONE;
                            end
                        end
                    end

                    S_DONE: begin
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                    end

                    default: begin
                        // IDLE: wait for the first arm.
                    end
                endcase
            end
        end
    end

    assign status = {done_r, busy_r, pre_short_r, {(29 - ADDR_W){1'b0}}, start_addr_r};

endmodule

// File: tb/tb_snap_trig_capture_ctrl.sv
// tb_snap_trig_capture_ctrl
// Table-driven capture scenarios for a 16-deep buffer, followed by hand-written
// sequences for re-arm during capture and asynchronous reset.
module tb_snap_trig_capture_ctrl;

    localparam int ADDR_W   = 4;
    localparam int OFFSET_W = 32;
    localparam int DEPTH    = 16;

    logic                user_clk;
    logic                user_rst_n;
    logic [31:0]         ctrl;
    logic [OFFSET_W-1:0] trig_offset;
    logic                trig;
    logic                din_valid;
    logic [ADDR_W-1:0]   bram_addr;
    logic                bram_we;
    logic [31:0]         status;

    int total = 0;
    int bad   = 0;

    snap_trig_capture_ctrl #(
        .ADDR_W   (ADDR_W),
        .OFFSET_W (OFFSET_W)
    ) dut (
        .user_clk    (user_clk),
        .user_rst_n  (user_rst_n),
        .ctrl        (ctrl),
        .trig_offset (trig_offset),
        .trig        (trig),
        .din_valid   (din_valid),
        .bram_addr   (bram_addr),
        .bram_we     (bram_we),
        .status      (status)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    typedef struct {
        string       name;
        logic [31:0] off;
        bit          force_v;         // 1: ctrl[2] supplies valid, 0: din_valid toggles 1010
        int          pre_cycles;      // armed cycles before the trigger
        int          exp_pre_writes;
        int          exp_post_writes;
        int          exp_first_addr;
        int          exp_skip;        // valid samples after the trigger that are not written
        int          exp_start;
        bit          exp_pre_short;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Apply inputs, clock once, sample just after the edge.
    task automatic step(input logic v, input logic t);
        din_valid = v;
        trig      = t;
        @(posedge user_clk);
        #1;
    endtask

    function automatic logic pat_vld(input bit force_v, input int k);
        return force_v ? 1'b1 : logic'(k % 2 == 0);
    endfunction

    task automatic run_vec(input vec_t v);
        int   k;
        int   exp_addr;
        int   pre_w;
        int   post_w;
        int   addr_err;
        int   first;
        int   prev;
        int   skip;
        int   last_we;
        int   done_cyc;
        int   late_we;
        logic vi;

        ctrl        = 32'd0;
        trig_offset = v.off;
        step(1'b0, 1'b0);

        // Arm with trigger and valid also high: both must be ignored.
        ctrl = {29'd0, v.force_v, 1'b0, 1'b1};
        step(1'b1, 1'b1);
        check($sformatf("%s_arm_we", v.name), 64'(bram_we), 64'd0);
        check($sformatf("%s_arm_addr", v.name), 64'(bram_addr), 64'd0);
        check($sformatf("%s_arm_busy", v.name), 64'(status[30]), 64'd1);
        check($sformatf("%s_arm_done", v.name), 64'(status[31]), 64'd0);
        check($sformatf("%s_arm_pre_short", v.name), 64'(status[29]), 64'd0);

        // Later offset changes must not take effect until the next arm.
        ctrl[0]     = 1'b0;
        trig_offset = 32'd7;

        k        = 0;
        exp_addr = 0;
        pre_w    = 0;
        addr_err = 0;
        for (int i = 0; i < v.pre_cycles; i++) begin
            vi = pat_vld(v.force_v, k);
            step(v.force_v ? 1'b0 : vi, 1'b0);
            k++;
            if (bram_we === 1'b1) begin
                pre_w++;
                if (int'(bram_addr) != (exp_addr % DEPTH)) addr_err++;
                exp_addr++;
            end
        end
        check($sformatf("%s_pre_writes", v.name), 64'(pre_w), 64'(v.exp_pre_writes));

        post_w   = 0;
        first    = -1;
        prev     = 0;
        skip     = 0;
        last_we  = -100;
        done_cyc = -1;
        for (int c = 0; c < 200; c++) begin
            vi = pat_vld(v.force_v, k);
            step(v.force_v ? 1'b0 : vi, c == 0);
            k++;
            if (bram_we === 1'b1) begin
                if (post_w == 0) first = int'(bram_addr);
                else if (int'(bram_addr) != ((prev + 1) % DEPTH)) addr_err++;
                prev    = int'(bram_addr);
                post_w++;
                last_we = c;
            end else if (post_w == 0 && vi) begin
                skip++;
            end
            if (status[31] === 1'b1) begin
                done_cyc = c;
                break;
            end
        end
        check($sformatf("%s_done_seen", v.name), 64'(done_cyc >= 0), 64'd1);
        check($sformatf("%s_post_writes", v.name), 64'(post_w), 64'(v.exp_post_writes));
        check($sformatf("%s_first_addr", v.name), 64'(first), 64'(v.exp_first_addr));
        check($sformatf("%s_skip", v.name), 64'(skip), 64'(v.exp_skip));
        check($sformatf("%s_addr_seq_err", v.name), 64'(addr_err), 64'd0);
        check($sformatf("%s_done_gap", v.name), 64'(done_cyc - last_we), 64'd1);
        check($sformatf("%s_start_addr", v.name), 64'(status[ADDR_W-1:0]), 64'(v.exp_start));
        check($sformatf("%s_pre_short", v.name), 64'(status[29]), 64'(v.exp_pre_short));
        check($sformatf("%s_busy_end", v.name), 64'(status[30]), 64'd0);

        // DONE ignores further triggers and samples.
        late_we = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            if (bram_we !== 1'b0) late_we++;
        end
        check($sformatf("%s_done_no_we", v.name), 64'(late_we), 64'd0);
        check($sformatf("%s_done_addr_held", v.name), 64'(bram_addr), 64'(prev));
        check($sformatf("%s_done_held", v.name), 64'(status[31]), 64'd1);
    endtask

    initial begin
        int n_we;

        tbl[0] = '{"off0_force",   32'd0,          1'b1, 3,  0,  16, 0, 0,  0,  1'b0};
        tbl[1] = '{"offp5",        32'd5,          1'b1, 2,  0,  16, 0, 5,  0,  1'b0};
        tbl[2] = '{"offm4_wrap",   -32'sd4,        1'b1, 20, 20, 12, 4, 0,  0,  1'b0};
        tbl[3] = '{"offm8_short",  -32'sd8,        1'b1, 3,  3,  8,  3, 0,  11, 1'b1};
        tbl[4] = '{"off0_toggle",  32'd0,          1'b0, 4,  0,  16, 0, 0,  0,  1'b0};
        tbl[5] = '{"offm100_clamp",-32'sd100,      1'b1, 20, 20, 1,  4, 0,  5,  1'b0};
        tbl[6] = '{"offp1",        32'd1,          1'b1, 0,  0,  16, 0, 1,  0,  1'b0};
        tbl[7] = '{"offp3_toggle", 32'd3,          1'b0, 2,  0,  16, 0, 3,  0,  1'b0};
        tbl[8] = '{"offmin_clamp", 32'h8000_0000,  1'b1, 2,  2,  1,  2, 0,  3,  1'b1};
        tbl[9] = '{"offp1000",     32'd1000,       1'b1, 1,  0,  16, 0, 15, 0,  1'b0};

        user_rst_n  = 1'b0;
        ctrl        = 32'd0;
        trig_offset = '0;
        trig        = 1'b0;
        din_valid   = 1'b0;
        @(posedge user_clk);
        #1;
        check("reset_we", 64'(bram_we), 64'd0);
        check("reset_addr", 64'(bram_addr), 64'd0);
        check("reset_status", 64'(status), 64'd0);
        @(negedge user_clk);
        user_rst_n = 1'b1;

        // IDLE ignores triggers and samples before the first arm.
        n_we = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            if (bram_we !== 1'b0) n_we++;
        end
        check("idle_no_we", 64'(n_we), 64'd0);
        check("idle_status", 64'(status), 64'd0);

        for (int i = 0; i < 10; i++) begin
            run_vec(tbl[i]);
        end

        // Re-arm in the middle of a capture.
        ctrl        = 32'd0;
        trig_offset = 32'd0;
        step(1'b0, 1'b0);
        ctrl = 32'h5;
        step(1'b0, 1'b0);
        ctrl = 32'h4;
        step(1'b0, 1'b1);
        check("mid_first_we", 64'(bram_we), 64'd1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        check("mid_addr", 64'(bram_addr), 64'd6);
        check("mid_busy", 64'(status[30]), 64'd1);
        ctrl = 32'h5;
        step(1'b0, 1'b0);
        check("rearm_we", 64'(bram_we), 64'd0);
        check("rearm_addr", 64'(bram_addr), 64'd0);
        check("rearm_done", 64'(status[31]), 64'd0);
        check("rearm_busy", 64'(status[30]), 64'd1);
        ctrl = 32'h4;
        step(1'b0, 1'b1);
        check("rearm_trig_we", 64'(bram_we), 64'd1);
        check("rearm_trig_addr", 64'(bram_addr), 64'd0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("rearm_cap_addr", 64'(bram_addr), 64'd2);

        // Asynchronous reset mid-capture clears outputs without waiting for a clock.
        #2;
        user_rst_n = 1'b0;
        #1;
        check("async_rst_we", 64'(bram_we), 64'd0);
        check("async_rst_addr", 64'(bram_addr), 64'd0);
        check("async_rst_status", 64'(status), 64'd0);
        @(negedge user_clk);
        user_rst_n = 1'b1;
        n_we = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            if (bram_we !== 1'b0) n_we++;
        end
        check("post_rst_no_we", 64'(n_we), 64'd0);
        check("post_rst_status", 64'(status), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
